// File: rtl/fdiv_pkg.sv
// Shared constants and types for the programmable clock divider.
package fdiv_pkg;
  localparam int unsigned DIV_W = 24;
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DEFAULT_DIV = 24'hFFFFFF;

  // Channel-index width; never below one bit so a single-channel build still has a port.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fdiv_chan.sv
// One divider channel: half-period counter with a shadow ratio that is
// only committed at a toggle, sync or while disabled.
module fdiv_chan
  import fdiv_pkg::*;
#(
  parameter int              WIDTH       = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             div_clk,
  output logic             tick,
  output logic             busy
);
  logic [WIDTH-1:0] r_cnt, r_active, r_shadow;
  logic             r_div_clk, r_tick, r_busy;
  logic [WIDTH-1:0] w_next_ratio;
  logic             w_tc, w_reload;

  // A write on the reload cycle goes straight into the active ratio.
  assign w_next_ratio = wr ? wdata : r_shadow;
  assign w_tc         = (r_cnt == r_active);
  assign w_reload     = !en || sync || w_tc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt     <= '0;
      r_active  <= DEFAULT_DIV;
      r_shadow  <= DEFAULT_DIV;
      r_div_clk <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (wr) r_shadow <= wdata;
      if (w_reload) begin
        r_active <= w_next_ratio;
        r_busy   <= 1'b0;
        r_cnt    <= '0;
      end
      if (!en) begin
        r_div_clk <= 1'b0;
        r_tick    <= 1'b0;
      end else if (sync) begin
        r_tick    <= r_div_clk;
        r_div_clk <= 1'b0;
      end else if (w_tc) begin
        r_div_clk <= ~r_div_clk;
        r_tick    <= 1'b1;
      end else begin
        // cnt < active here, so the increment cannot wrap.
        r_cnt  <= r_cnt + 1'b1;
        r_tick <= 1'b0;
        if (wr) r_busy <= 1'b1;
      end
    end
  end

  assign div_clk = r_div_clk;
  assign tick    = r_tick;
  assign busy    = r_busy;
endmodule

// File: rtl/fdiv_prog.sv
// Multi-channel runtime-programmable 50%-duty clock divider with global sync.
module fdiv_prog
  import fdiv_pkg::*;
#(
  parameter int               N_CH        = 4,
  parameter int               WIDTH       = 24,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(fdiv_pkg::DEFAULT_DIV)
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic [N_CH-1:0]                   en,
  input  logic                              sync,
  input  logic                              cfg_we,
  input  logic [fdiv_pkg::ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                  cfg_div,
  output logic [N_CH-1:0]                   div_clk,
  output logic [N_CH-1:0]                   tick,
  output logic [N_CH-1:0]                   busy
);
  logic [N_CH-1:0] w_wr;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Indices at or above N_CH match no channel, so such writes vanish.
    assign w_wr[i] = cfg_we && (int'(cfg_ch) == i);

    fdiv_chan #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .nrst   (nrst),
      .en     (en[i]),
      .sync   (sync),
      .wr     (w_wr[i]),
      .wdata  (cfg_div),
      .div_clk(div_clk[i]),
      .tick   (tick[i]),
      .busy   (busy[i])
    );
  end
endmodule

// File: tb/tb_fdiv_prog.sv
// Self-checking bench for fdiv_prog: vector table, directed corners, random vs model.
module tb_fdiv_prog;
  logic        clk = 1'b0;
  logic        nrst, sync, cfg_we;
  logic [3:0]  en;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_div;
  logic [3:0]  div_clk, tick, busy;

  // small instance: 3 channels so an out-of-range index exists; 4-bit ratio for max-ratio runs
  logic        nrst3, sync3, we3;
  logic [2:0]  en3, clk3o, tick3, busy3;
  logic [1:0]  ch3;
  logic [3:0]  div3;

  int total = 0, bad = 0, cyc = 0;

  fdiv_prog u_dut (
    .clk(clk), .nrst(nrst), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .div_clk(div_clk), .tick(tick), .busy(busy)
  );

  fdiv_prog #(.N_CH(3), .WIDTH(4), .DEFAULT_DIV(4'hF)) u_dut3 (
    .clk(clk), .nrst(nrst3), .en(en3), .sync(sync3), .cfg_we(we3),
    .cfg_ch(ch3), .cfg_div(div3), .div_clk(clk3o), .tick(tick3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  en;
    logic        sync;
    logic        we;
    logic [1:0]  ch;
    logic [23:0] div;
    logic [3:0]  xclk, xtick, xbusy;
  } vec_t;
  vec_t vecs[13];

  // reference model state
  logic [23:0] m_act[4], m_shd[4];
  bit          m_lvl[4], m_tk[4], m_pend[4];
  longint      m_rem[4];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    nrst = 1'b0; en = '0; sync = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    step(); step();
    nrst = 1'b1;
  endtask

  task automatic write(input int ch, input int div);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 24'(div);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input int lim, output int t);
    t = -1;
    for (int k = 0; k < lim; k++) begin
      step();
      if (tick[ch]) begin t = cyc; break; end
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL wait_tick ch%0d got=timeout exp=tick within %0d", ch, lim);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 24'hFFFFFF; m_shd[i] = 24'hFFFFFF;
      m_lvl[i] = 0; m_tk[i] = 0; m_pend[i] = 0;
      m_rem[i] = 64'h1000000;
    end
  endtask

  // Each half period lasts ratio+1 enabled cycles; a new ratio is adopted when
  // the half ends, on sync, or whenever the channel is off.
  task automatic model_step(input logic [3:0] e, input logic s, input logic w,
                            input logic [1:0] c, input logic [23:0] d);
    for (int i = 0; i < 4; i++) begin
      bit          wi;
      logic [23:0] nxt;
      bit          adopt;
      wi    = w && (int'(c) == i);
      nxt   = wi ? d : m_shd[i];
      adopt = 0;
      if (!e[i]) begin
        m_lvl[i] = 0; m_tk[i] = 0; adopt = 1;
      end else if (s) begin
        m_tk[i] = m_lvl[i]; m_lvl[i] = 0; adopt = 1;
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_lvl[i] = !m_lvl[i]; m_tk[i] = 1; adopt = 1;
        end else begin
          m_tk[i] = 0;
          if (wi) begin m_shd[i] = d; m_pend[i] = 1; end
        end
      end
      if (adopt) begin
        m_act[i] = nxt; m_shd[i] = nxt; m_pend[i] = 0;
        m_rem[i] = longint'(nxt) + 1;
      end
    end
  endtask

  initial begin
    int t0, t1, t2, t3, r0, r2, r, f;
    logic [3:0] ec, et, eb;

    nrst3 = 1'b0; en3 = '0; sync3 = 1'b0; we3 = 1'b0; ch3 = '0; div3 = '0;
    do_reset();
    chk("reset_clk", int'(div_clk), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_busy", int'(busy), 0);

    // en, sync, we, ch, div, exp clk, exp tick, exp busy
    vecs[0]  = '{4'b0000, 0, 1, 0, 24'd3, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[2]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[3]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0000, 4'b0000};
    vecs[4]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0001, 4'b0001, 4'b0000};
    vecs[5]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0001, 4'b0000, 4'b0000};
    vecs[6]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0001, 4'b0000, 4'b0000};
    vecs[7]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0001, 4'b0000, 4'b0000};
    vecs[8]  = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0001, 4'b0000};
    vecs[9]  = '{4'b0001, 0, 1, 0, 24'd5, 4'b0000, 4'b0000, 4'b0001};
    vecs[10] = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0000, 4'b0001};
    vecs[11] = '{4'b0001, 0, 0, 0, 24'd0, 4'b0000, 4'b0000, 4'b0001};
    vecs[12] = '{4'b0001, 0, 0, 0, 24'd0, 4'b0001, 4'b0001, 4'b0000};
    for (int v = 0; v < 13; v++) begin
      en = vecs[v].en; sync = vecs[v].sync; cfg_we = vecs[v].we;
      cfg_ch = vecs[v].ch; cfg_div = vecs[v].div;
      step();
      chk($sformatf("vec%0d_clk", v), int'(div_clk), int'(vecs[v].xclk));
      chk($sformatf("vec%0d_tick", v), int'(tick), int'(vecs[v].xtick));
      chk($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].xbusy));
    end
    cfg_we = 1'b0;

    // div=0 -> clk/2 with a tick every cycle
    do_reset();
    write(1, 0);
    en = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("div0_clk", int'(div_clk[1]), k % 2);
      chk("div0_tick", int'(tick[1]), 1);
    end

    // ratio change mid half-period completes the old half first
    do_reset();
    write(0, 9);
    en = 4'b0001;
    wait_tick(0, 40, t0);
    chk("chg_rise", int'(div_clk[0]), 1);
    repeat (3) step();
    write(0, 2);
    chk("chg_busy_set", int'(busy[0]), 1);
    wait_tick(0, 20, t1);
    chk("chg_old_half", t1 - t0, 10);
    chk("chg_busy_clr", int'(busy[0]), 0);
    wait_tick(0, 20, t2);
    chk("chg_new_half_a", t2 - t1, 3);
    wait_tick(0, 20, t3);
    chk("chg_new_half_b", t3 - t2, 3);

    // sync phase-aligns ch0 (div4) and ch2 (div6)
    do_reset();
    write(0, 4);
    write(2, 6);
    en = 4'b0101;
    repeat (13) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_low", int'({div_clk[2], div_clk[0]}), 0);
    r0 = -1; r2 = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (div_clk[0] && r0 < 0) r0 = k;
      if (div_clk[2] && r2 < 0) r2 = k;
    end
    chk("sync_rise_ch0", r0, 5);
    chk("sync_rise_ch2", r2, 7);

    // asynchronous reset between clock edges
    do_reset();
    write(0, 5);
    en = 4'b0001;
    repeat (6) step();
    chk("arst_pre_tick", int'(tick[0]), 1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_clk", int'(div_clk), 0);
    chk("arst_tick", int'(tick), 0);
    nrst = 1'b1;
    repeat (20) step();
    chk("arst_ratio_dflt", int'(div_clk[0]), 0);
    en = 4'b0000;

    // small instance: max ratio, out-of-range index, reset restores default
    nrst3 = 1'b1; en3 = 3'b001;
    r = -1; f = -1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (clk3o[0] && r < 0) r = k;
      if (!clk3o[0] && r > 0 && f < 0) f = k;
    end
    chk("max_rise", r, 16);
    chk("max_fall", f, 32);
    we3 = 1'b1; ch3 = 2'd3; div3 = 4'd1;
    step();
    we3 = 1'b0;
    chk("oor_busy", int'(busy3), 0);
    t0 = -1;
    for (int k = 34; k <= 60; k++) begin
      step();
      if (tick3[0]) begin t0 = k; break; end
    end
    chk("oor_period", t0, 48);
    we3 = 1'b1; ch3 = 2'd0; div3 = 4'd2;
    step();
    we3 = 1'b0;
    chk("s3_busy_set", int'(busy3), 1);
    #2 nrst3 = 1'b0;
    #1;
    chk("s3_arst_clk", int'(clk3o), 0);
    chk("s3_arst_busy", int'(busy3), 0);
    nrst3 = 1'b1;
    r = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (clk3o[0] && r < 0) r = k;
    end
    chk("s3_dflt_after_rst", r, 16);
    en3 = '0;

    // randomized run against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(15) == 0) en = en ^ (4'b0001 << $urandom_range(3));
      sync    = ($urandom_range(39) == 0);
      cfg_we  = ($urandom_range(2) == 0);
      cfg_ch  = 2'($urandom_range(3));
      cfg_div = 24'($urandom_range(7));
      model_step(en, sync, cfg_we, cfg_ch, cfg_div);
      step();
      for (int i = 0; i < 4; i++) begin
        ec[i] = m_lvl[i]; et[i] = m_tk[i]; eb[i] = m_pend[i];
      end
      chk("rand_clk", int'(div_clk), int'(ec));
      chk("rand_tick", int'(tick), int'(et));
      chk("rand_busy", int'(busy), int'(eb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
